// File: rtl/pong_pkg.sv
// Shared geometry, game states and score formatting for the Pong sequencer.
package pong_pkg;

   localparam int SCREEN_W     = 640;
   localparam int SCREEN_H     = 480;
   localparam int BALL_SIZE    = 10;
   localparam int PADDLE_W     = 10;
   localparam int PADDLE_H     = 60;
   localparam int PADDLE_Y_MAX = SCREEN_H - PADDLE_H;               // 420
   localparam int BALL_Y_MAX   = SCREEN_H - BALL_SIZE;              // 470
   localparam int CENTER_X     = (SCREEN_W - BALL_SIZE) / 2;        // 315
   localparam int CENTER_Y     = (SCREEN_H - BALL_SIZE) / 2;        // 235
   localparam int PADDLE_Y_RST = 210;
   // Ball x where it touches the face of a paddle, and where it is out.
   localparam int LEFT_X_LIM   = PADDLE_W;                          // 10
   localparam int RIGHT_X_LIM  = SCREEN_W - PADDLE_W - BALL_SIZE;   // 620
   localparam int RIGHT_OUT_X  = SCREEN_W - BALL_SIZE;              // 630

   localparam int SHOW_BIT = 7;

   typedef enum logic [1:0] {
      SERVE     = 2'd0,
      PLAY      = 2'd1,
      POINT     = 2'd2,
      GAME_OVER = 2'd3
   } game_state_t;

   // Renderer score byte: show flag in bit 7, BCD digit in [3:0].
   function automatic logic [7:0] fmt_score(input logic show, input logic [3:0] digit);
      logic [7:0] r;
      r           = {4'b0000, digit};
      r[SHOW_BIT] = show;
      return r;
   endfunction

endpackage

// File: rtl/pong_paddle_ctrl.sv
// One paddle: moves by PADDLE_SPEED per enabled tick, clamped to the screen.
module pong_paddle_ctrl
   import pong_pkg::*;
#(
   parameter int PADDLE_SPEED = 6
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en_i,
   input  logic       load_i,
   input  logic       up_i,
   input  logic       dn_i,
   output logic [9:0] y_o
);

   localparam logic signed [10:0] STEP  = 11'(PADDLE_SPEED);
   localparam logic signed [10:0] Y_MAX = 11'(PADDLE_Y_MAX);
   localparam logic [9:0]         Y_RST = 10'(PADDLE_Y_RST);

   logic [9:0]         y_q, y_d;
   logic signed [10:0] y_up, y_dn;

   // Candidate positions in 11-bit signed so going past 0 cannot wrap.
   assign y_up = $signed({1'b0, y_q}) - STEP;
   assign y_dn = $signed({1'b0, y_q}) + STEP;

   // Next position: one direction only moves, both/neither holds.
   always_comb begin
      y_d = y_q;
      if (up_i && !dn_i)
         y_d = (y_up < 11'sd0) ? 10'd0 : y_up[9:0];
      else if (dn_i && !up_i)
         y_d = (y_dn > Y_MAX) ? Y_MAX[9:0] : y_dn[9:0];
   end

   // Position register; a load (game restart) recentres the paddle.
   always_ff @(posedge clk) begin
      if (!rst_n)
         y_q <= Y_RST;
      else if (load_i)
         y_q <= Y_RST;
      else if (en_i)
         y_q <= y_d;
   end

   assign y_o = y_q;

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong frame sequencer: ball motion, paddles, scoring and serve/point/game-over flow.
module pong_game_ctrl
   import pong_pkg::*;
#(
   parameter int BALL_SPEED   = 4,
   parameter int PADDLE_SPEED = 6,
   parameter int SERVE_FRAMES = 60,
   parameter int POINT_FRAMES = 90,
   parameter int MAX_SCORE    = 9
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       frame_tick,
   input  logic       btn_l_up,
   input  logic       btn_l_dn,
   input  logic       btn_r_up,
   input  logic       btn_r_dn,
   input  logic       btn_start,
   output logic [9:0] ball_x,
   output logic [9:0] ball_y,
   output logic [9:0] paddle_l_y,
   output logic [9:0] paddle_r_y,
   output logic [7:0] score_l,
   output logic [7:0] score_r,
   output logic       game_over
);

   localparam int CNT_MAX = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0]   SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
   localparam logic [CNT_W-1:0]   POINT_LAST = CNT_W'(POINT_FRAMES - 1);
   localparam logic signed [10:0] BSTEP      = 11'(BALL_SPEED);
   localparam logic signed [10:0] Y_MAX_S    = 11'(BALL_Y_MAX);
   localparam logic signed [10:0] L_LIM_S    = 11'(LEFT_X_LIM);
   localparam logic signed [10:0] R_LIM_S    = 11'(RIGHT_X_LIM);
   localparam logic [9:0]         CX         = 10'(CENTER_X);
   localparam logic [9:0]         CY         = 10'(CENTER_Y);
   localparam logic [3:0]         SCORE_MAX  = 4'(MAX_SCORE);

   game_state_t      state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [9:0]       ball_x_q, ball_y_q;
   logic             dx_neg_q, dy_neg_q;
   logic [3:0]       score_l_q, score_r_q;
   logic             show_q, game_over_q;
   logic             start_q, start_pend_q;

   logic             start_edge, restart, paddle_en, paddle_load;
   logic [9:0]       pad_l_y, pad_r_y;

   logic signed [10:0] nx, ny;
   logic [9:0]         ball_x_d, ball_y_d;
   logic               dx_neg_d, dy_neg_d;
   logic               ovl_l, ovl_r, miss_l, miss_r;

   function automatic logic [3:0] sat_inc(input logic [3:0] s);
      return (s >= SCORE_MAX) ? s : s + 4'd1;
   endfunction

   assign start_edge  = btn_start & ~start_q;
   assign restart     = start_pend_q | start_edge;
   assign paddle_en   = frame_tick & ((state_q == SERVE) | (state_q == PLAY));
   assign paddle_load = frame_tick & (state_q == GAME_OVER) & restart;

   pong_paddle_ctrl #(.PADDLE_SPEED(PADDLE_SPEED)) u_pad_l (
      .clk   (clk),
      .rst_n (rst_n),
      .en_i  (paddle_en),
      .load_i(paddle_load),
      .up_i  (btn_l_up),
      .dn_i  (btn_l_dn),
      .y_o   (pad_l_y)
   );

   pong_paddle_ctrl #(.PADDLE_SPEED(PADDLE_SPEED)) u_pad_r (
      .clk   (clk),
      .rst_n (rst_n),
      .en_i  (paddle_en),
      .load_i(paddle_load),
      .up_i  (btn_r_up),
      .dn_i  (btn_r_dn),
      .y_o   (pad_r_y)
   );

   // Ball step for one PLAY tick; bounces and paddle tests use pre-tick values.
   always_comb begin
      nx = dx_neg_q ? ($signed({1'b0, ball_x_q}) - BSTEP) : ($signed({1'b0, ball_x_q}) + BSTEP);
      ny = dy_neg_q ? ($signed({1'b0, ball_y_q}) - BSTEP) : ($signed({1'b0, ball_y_q}) + BSTEP);

      ball_y_d = ny[9:0];
      dy_neg_d = dy_neg_q;
      if (ny <= 11'sd0) begin
         ball_y_d = 10'd0;
         dy_neg_d = 1'b0;
      end else if (ny >= Y_MAX_S) begin
         ball_y_d = 10'(BALL_Y_MAX);
         dy_neg_d = 1'b1;
      end

      ovl_l = (({1'b0, ball_y_q} + 11'(BALL_SIZE)) > {1'b0, pad_l_y}) &&
              ({1'b0, ball_y_q} < ({1'b0, pad_l_y} + 11'(PADDLE_H)));
      ovl_r = (({1'b0, ball_y_q} + 11'(BALL_SIZE)) > {1'b0, pad_r_y}) &&
              ({1'b0, ball_y_q} < ({1'b0, pad_r_y} + 11'(PADDLE_H)));

      ball_x_d = nx[9:0];
      dx_neg_d = dx_neg_q;
      miss_l   = 1'b0;
      miss_r   = 1'b0;
      if (dx_neg_q && (nx <= L_LIM_S)) begin
         if (ovl_l) begin
            ball_x_d = 10'(LEFT_X_LIM);
            dx_neg_d = 1'b0;
         end else begin
            // Left lost: next serve heads back toward the left.
            ball_x_d = 10'd0;
            dx_neg_d = 1'b1;
            miss_l   = 1'b1;
         end
      end else if (!dx_neg_q && (nx >= R_LIM_S)) begin
         if (ovl_r) begin
            ball_x_d = 10'(RIGHT_X_LIM);
            dx_neg_d = 1'b1;
         end else begin
            ball_x_d = 10'(RIGHT_OUT_X);
            dx_neg_d = 1'b0;
            miss_r   = 1'b1;
         end
      end
   end

   // Game FSM with registered ball, score and flag outputs; advances on frame_tick.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= SERVE;
         cnt_q        <= '0;
         ball_x_q     <= CX;
         ball_y_q     <= CY;
         dx_neg_q     <= 1'b0;
         dy_neg_q     <= 1'b0;
         score_l_q    <= 4'd0;
         score_r_q    <= 4'd0;
         show_q       <= 1'b1;
         game_over_q  <= 1'b0;
         start_q      <= 1'b0;
         start_pend_q <= 1'b0;
      end else begin
         start_q <= btn_start;
         // Only a press made while the game is over is remembered.
         if ((state_q == GAME_OVER) && start_edge)
            start_pend_q <= 1'b1;

         if (frame_tick) begin
            case (state_q)
               SERVE: begin
                  if (cnt_q == SERVE_LAST) begin
                     state_q <= PLAY;
                     cnt_q   <= '0;
                     show_q  <= 1'b0;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
               PLAY: begin
                  ball_x_q <= ball_x_d;
                  ball_y_q <= ball_y_d;
                  dx_neg_q <= dx_neg_d;
                  dy_neg_q <= dy_neg_d;
                  if (miss_l || miss_r) begin
                     state_q <= POINT;
                     cnt_q   <= '0;
                     show_q  <= 1'b1;
                  end
                  if (miss_l) score_r_q <= sat_inc(score_r_q);
                  if (miss_r) score_l_q <= sat_inc(score_l_q);
               end
               POINT: begin
                  if (cnt_q == POINT_LAST) begin
                     cnt_q    <= '0;
                     ball_x_q <= CX;
                     ball_y_q <= CY;
                     if ((score_l_q == SCORE_MAX) || (score_r_q == SCORE_MAX)) begin
                        state_q     <= GAME_OVER;
                        game_over_q <= 1'b1;
                     end else begin
                        state_q <= SERVE;
                     end
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
               GAME_OVER: begin
                  if (restart) begin
                     state_q      <= SERVE;
                     cnt_q        <= '0;
                     score_l_q    <= 4'd0;
                     score_r_q    <= 4'd0;
                     game_over_q  <= 1'b0;
                     start_pend_q <= 1'b0;
                  end
               end
               default: state_q <= SERVE;
            endcase
         end
      end
   end

   assign ball_x     = ball_x_q;
   assign ball_y     = ball_y_q;
   assign paddle_l_y = pad_l_y;
   assign paddle_r_y = pad_r_y;
   assign score_l    = fmt_score(show_q, score_l_q);
   assign score_r    = fmt_score(show_q, score_r_q);
   assign game_over  = game_over_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Randomized bench for pong_game_ctrl with a frame-level behavioural model.
module tb_pong_game_ctrl;

   localparam int BS   = 4;
   localparam int PS   = 6;
   localparam int SF   = 60;
   localparam int PF   = 90;
   localparam int MAXS = 9;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       frame_tick = 1'b0;
   logic       btn_l_up = 1'b0, btn_l_dn = 1'b0, btn_r_up = 1'b0, btn_r_dn = 1'b0;
   logic       btn_start = 1'b0;
   logic [9:0] ball_x, ball_y, paddle_l_y, paddle_r_y;
   logic [7:0] score_l, score_r;
   logic       game_over;

   int checks = 0;
   int errors = 0;

   // Model state: phase 0 serve, 1 play, 2 point, 3 over.
   int m_bx, m_by, m_dx, m_dy, m_pl, m_pr, m_sl, m_sr, m_ph, m_cnt;
   bit m_pend, m_prev;

   pong_game_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .frame_tick(frame_tick),
      .btn_l_up  (btn_l_up),
      .btn_l_dn  (btn_l_dn),
      .btn_r_up  (btn_r_up),
      .btn_r_dn  (btn_r_dn),
      .btn_start (btn_start),
      .ball_x    (ball_x),
      .ball_y    (ball_y),
      .paddle_l_y(paddle_l_y),
      .paddle_r_y(paddle_r_y),
      .score_l   (score_l),
      .score_r   (score_r),
      .game_over (game_over)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int pad_move(input int y, input bit up, input bit dn);
      int r;
      r = y;
      if (up && !dn) r = (y - PS < 0) ? 0 : y - PS;
      if (dn && !up) r = (y + PS > 420) ? 420 : y + PS;
      return r;
   endfunction

   task automatic model_reset();
      m_bx = 315; m_by = 235; m_dx = 1; m_dy = 1;
      m_pl = 210; m_pr = 210; m_sl = 0; m_sr = 0;
      m_ph = 0; m_cnt = 0; m_pend = 0; m_prev = 0;
   endtask

   // One clock edge of game rules, using the inputs present at that edge.
   task automatic model_step();
      int  nx, ny, npl, npr;
      bit  edge_s, pt;
      edge_s = btn_start && !m_prev;
      m_prev = btn_start;
      if (m_ph == 3 && edge_s) m_pend = 1;
      if (frame_tick) begin
         npl = pad_move(m_pl, btn_l_up, btn_l_dn);
         npr = pad_move(m_pr, btn_r_up, btn_r_dn);
         case (m_ph)
            0: begin
               m_pl = npl; m_pr = npr;
               m_cnt++;
               if (m_cnt == SF) begin m_ph = 1; m_cnt = 0; end
            end
            1: begin
               pt = 0;
               nx = m_bx + BS * m_dx;
               ny = m_by + BS * m_dy;
               if (ny <= 0) begin ny = 0; m_dy = 1; end
               else if (ny >= 470) begin ny = 470; m_dy = -1; end
               if (m_dx < 0 && nx <= 10) begin
                  if (m_by + 10 > m_pl && m_by < m_pl + 60) begin nx = 10; m_dx = 1; end
                  else begin nx = 0; m_dx = -1; pt = 1; if (m_sr < MAXS) m_sr++; end
               end else if (m_dx > 0 && nx >= 620) begin
                  if (m_by + 10 > m_pr && m_by < m_pr + 60) begin nx = 620; m_dx = -1; end
                  else begin nx = 630; m_dx = 1; pt = 1; if (m_sl < MAXS) m_sl++; end
               end
               m_bx = nx; m_by = ny;
               m_pl = npl; m_pr = npr;
               if (pt) begin m_ph = 2; m_cnt = 0; end
            end
            2: begin
               m_cnt++;
               if (m_cnt == PF) begin
                  m_cnt = 0; m_bx = 315; m_by = 235;
                  m_ph = (m_sl == MAXS || m_sr == MAXS) ? 3 : 0;
               end
            end
            default: begin
               if (m_pend) begin
                  m_sl = 0; m_sr = 0; m_pl = 210; m_pr = 210;
                  m_ph = 0; m_cnt = 0; m_pend = 0;
               end
            end
         endcase
      end
   endtask

   // Inputs only change at negedge+1, so here they equal what the last posedge saw.
   always @(negedge clk) begin
      if (!rst_n) model_reset();
      else model_step();
      check("ball_x", ball_x, m_bx);
      check("ball_y", ball_y, m_by);
      check("paddle_l_y", paddle_l_y, m_pl);
      check("paddle_r_y", paddle_r_y, m_pr);
      check("score_l", score_l, ((m_ph != 1) ? 128 : 0) + m_sl);
      check("score_r", score_r, ((m_ph != 1) ? 128 : 0) + m_sr);
      check("game_over", game_over, (m_ph == 3) ? 1 : 0);
   end

   task automatic tick(input bit lu, input bit ld, input bit ru, input bit rd, input bit st);
      @(negedge clk); #1;
      btn_l_up = lu; btn_l_dn = ld; btn_r_up = ru; btn_r_dn = rd; btn_start = st;
      frame_tick = 1'b1;
      @(negedge clk); #1;
      frame_tick = 1'b0;
   endtask

   task automatic rnd_tick(input bit allow_start);
      tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           allow_start && ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 3) == 0) @(negedge clk);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_bx"}, ball_x, 315);
      check({tag, "_by"}, ball_y, 235);
      check({tag, "_pl"}, paddle_l_y, 210);
      check({tag, "_pr"}, paddle_r_y, 210);
      check({tag, "_sl"}, score_l, 8'h80);
      check({tag, "_sr"}, score_r, 8'h80);
      check({tag, "_go"}, game_over, 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      repeat (3) @(negedge clk);
      #1 rst_n = 1'b1;
      check_reset_vals("rst0");

      // Serve phase: left up (then both, then up again), right down to its clamp.
      for (int k = 1; k <= SF; k++) begin
         tick(1'b1, (k > 30 && k <= 40), 1'b0, 1'b1, 1'b0);
         if (k == 1)  check("pl_k1", paddle_l_y, 204);
         if (k == 30) check("pl_k30", paddle_l_y, 30);
         if (k == 40) check("pl_both_held", paddle_l_y, 30);
         if (k == 59) check("sl_serve_show", score_l, 8'h80);
         if (k == SF) begin
            check("pl_clamp0", paddle_l_y, 0);
            check("pr_clamp420", paddle_r_y, 420);
            check("bx_serve", ball_x, 315);
            check("sl_play", score_l, 8'h00);
            check("sr_play", score_r, 8'h00);
         end
      end
      tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("bx_first", ball_x, 319);
      check("by_first", ball_y, 239);

      // Random play until one side reaches the winning score.
      n = 0;
      while (m_ph != 3 && n < 15000) begin
         rnd_tick(1'b1);
         n++;
      end
      btn_start = 1'b0;
      check("go_flag", game_over, 1);
      check("go_score9", (score_l == 8'h89) || (score_r == 8'h89), 1);
      repeat (3) begin
         tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
         check("go_hold", game_over, 1);
      end

      // Start press between ticks must be remembered until the next tick.
      @(negedge clk); #1 btn_start = 1'b1;
      @(negedge clk); #1 btn_start = 1'b0;
      repeat (2) @(negedge clk);
      tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      check_reset_vals("restart");

      // Get into PLAY, then pulse reset with a coincident tick.
      n = 0;
      while (m_ph != 1 && n < 200) begin
         rnd_tick(1'b0);
         n++;
      end
      repeat (5) rnd_tick(1'b0);
      @(negedge clk); #1;
      rst_n = 1'b0; frame_tick = 1'b1;
      @(negedge clk); #1;
      rst_n = 1'b1; frame_tick = 1'b0;
      check_reset_vals("midreset");

      repeat (300) rnd_tick(1'b1);
      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
Frame-rate game sequencer for Pong. It owns ball position and velocity, both paddle positions, scores and the serve/point/game-over flow. It advances the game state once per frame on a frame_tick pulse from the VGA timing block. Its outputs feed the renderer directly: scores use bit 7 as the "display" flag and bits [3:0] as the digit.

Parameters:
BALL_SPEED, 4, ball displacement per frame on each axis (pixels)
PADDLE_SPEED, 6, paddle displacement per frame (pixels)
SERVE_FRAMES, 60, frames the ball is held at centre before launch
POINT_FRAMES, 90, frames the score stays displayed after a point
MAX_SCORE, 9, score that ends the game (1..9)

Ports:
clk  in  1  system/pixel clock
rst_n  in  1  synchronous active-low reset
frame_tick  in  1  one-cycle pulse per frame, at start of vertical blanking
btn_l_up  in  1  left paddle up (level)
btn_l_dn  in  1  left paddle down (level)
btn_r_up  in  1  right paddle up (level)
btn_r_dn  in  1  right paddle down (level)
btn_start  in  1  restart after game over (level; rising edge detected internally)
ball_x  out  10  ball top-left x
ball_y  out  10  ball top-left y
paddle_l_y  out  10  left paddle top y
paddle_r_y  out  10  right paddle top y
score_l  out  8  {show, 3'b0, digit} for the left player
score_r  out  8  {show, 3'b0, digit} for the right player
game_over  out  1  high while in GAME_OVER

Behaviour:
- Only one clock and one reset exist: clk, with rst_n synchronous and active-low.
- Geometry is fixed:
  - screen 640x480
  - ball 10x10
  - paddles 10x60
  - left paddle columns 0..9, right paddle columns 630..639
- All outputs are registered. State changes only on cycles where frame_tick=1, except start-edge detection and reset. Outputs reflect a tick one cycle later.
- Reset values:
  - ball (315,235); paddles 210; internal scores 0
  - score_l = score_r = 8'h80
  - game_over = 0
  - dx = +BALL_SPEED, dy = +BALL_SPEED
  - state SERVE; frame counter 0
- Reset asserted mid-game restores all reset values on the next clk edge.
- States:
  - SERVE:
    - Ball held at centre; show=1; paddles move.
    - Counter increments per tick. After SERVE_FRAMES ticks, go to PLAY (counter cleared).
  - PLAY:
    - show=0; paddles and ball move every tick.
  - POINT:
    - Ball frozen at its last position; show=1; paddles frozen.
    - After POINT_FRAMES ticks: if either score = MAX_SCORE, go to GAME_OVER; else reset ball to centre and go to SERVE.
  - GAME_OVER:
    - Ball at centre; show=1; game_over=1; paddles frozen.
    - A btn_start rising edge (held until the next tick) clears scores and paddles to 210 and goes to SERVE. Start edges seen in other states are discarded.
- Paddle update per tick:
  - up only: y -= PADDLE_SPEED
  - down only: y += PADDLE_SPEED
  - both or neither: no change
  - Clamp to [0,420]. Compute in signed 11-bit so no 10-bit wrap occurs.
- Ball update per tick in PLAY uses signed 11-bit arithmetic: nx = x+dx, ny = y+dy.
  - Vertical:
    - if ny <= 0: ny=0, dy=+
    - if ny >= 470: ny=470, dy=-
  - Left edge (dx<0 and nx <= 10):
    - Hit if ball_y+10 > paddle_l_y and ball_y < paddle_l_y+60. Result: nx=10, dx=+.
    - Otherwise right scores: nx=0, enter POINT.
  - Right edge (dx>0 and nx >= 620):
    - Symmetric against paddle_r_y; hit clamps nx=620, dx=-.
    - Miss: left scores, nx=630, enter POINT.
  - Vertical and horizontal resolution are independent within the same tick (corner hits are legal).
  - Paddle comparisons use pre-tick paddle values.
- Scoring:
  - Scores saturate at MAX_SCORE.
  - After a point, dx for the next serve points toward the player who lost it. dy keeps its sign.
- Scores never exceed 9, so the digit field is always a valid BCD digit.

Decomposition:
- Shared package pong_pkg holds:
  - SCREEN_W/H, BALL_SIZE, PADDLE_W/H, PADDLE_Y_MAX=420, BALL_Y_MAX=470, CENTER_X/Y
  - typedef enum game_state_t {SERVE, PLAY, POINT, GAME_OVER}
  - score format helper (show bit index 7)
- Sub-module pong_paddle_ctrl (up/dn/tick -> clamped y, parameter PADDLE_SPEED) is instantiated twice.

Test Plan:
1. Reset, then 60 ticks -> ball stays at (315,235) with score_l=8'h80. The cycle after tick 60, the state is PLAY and score_l=8'h00; the next tick gives ball (319,239).
2. Hold btn_l_up for 40 ticks from y=210 -> paddle_l_y goes 204, 198, ... and saturates at 0 with no wrap. Both buttons held -> no change.
3. Ball at y=468, dy=+4, one tick -> ball_y=470 and dy negative; the next tick gives 466.
4. Ball x=12, dx=-4, y=200, paddle_l_y=180 -> ball_x=10 and dx=+4. Same case with paddle_l_y=0 -> score_r=8'h81, POINT held 90 ticks, then serve with dx=-4.
5. Score right to 9 -> GAME_OVER with game_over=1 and score_r=8'h89. A start pulse mid-PLAY earlier was ignored. btn_start edge -> scores 8'h80/8'h80, paddles 210, state SERVE.
6. Assert rst_n=0 for one cycle mid-PLAY -> every output equals its reset value on the next edge.
